// File: rtl/fpadd_seq_if.sv
// Request/response bundle between a core and the fpadd_seq sequencer.
// The master issues requests and consumes results; the slave is the sequencer.
interface fpadd_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [2:0]  in_rm;
  logic [2:0]  in_op;
  logic        in_p;
  logic        in_oven;
  logic        in_unen;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic [4:0]  out_flags;
  logic        out_denorm;
  logic [4:0]  acc_flags;
  logic        clr_flags;

  modport master (
    output in_valid, in_a, in_b, in_rm, in_op, in_p, in_oven, in_unen, out_ready, clr_flags,
    input  in_ready, out_valid, out_res, out_flags, out_denorm, acc_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rm, in_op, in_p, in_oven, in_unen, out_ready, clr_flags,
    output in_ready, out_valid, out_res, out_flags, out_denorm, acc_flags
  );
endinterface

// File: rtl/fpadd_seq.sv
// Combinational IEEE-754 adder (fpadd) plus a multicycle sequencer that feeds it
// registered operands, samples it after LAT cycles and keeps sticky exception flags.
module fpadd (
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic [2:0]  rm,
  input  logic [2:0]  op_type,
  input  logic        P,
  input  logic        OvEn,
  input  logic        UnEn,
  output logic [63:0] result,
  output logic [4:0]  Flags,
  output logic        Denorm
);
  logic [10:0] ea_f, eb_f, emax_f, ea, eb, e_big, d, fe;
  logic [51:0] fa, fb;
  logic [55:0] x_big, x_small, x_sh, n, rbits, half;
  logic [56:0] sum;
  logic [52:0] keep;
  logic [53:0] kr;
  logic [6:0]  lz, sh;
  logic [5:0]  lsb;
  logic signed [13:0] er, adj;
  logic sa, sb, a_ge, s_big, eff_sub, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
  logic inexact, inc, hidden, tiny, ovf, to_inf;

  always_comb begin
    // NOTE: result and Flags get defaults before any conditional override, so no path infers a latch.
    result = '0;
    Flags  = '0;
    ea_f   = P ? {3'b0, op1[62:55]} : op1[62:52];
    eb_f   = P ? {3'b0, op2[62:55]} : op2[62:52];
    fa     = P ? {op1[54:32], 29'b0} : op1[51:0];
    fb     = P ? {op2[54:32], 29'b0} : op2[51:0];
    emax_f = P ? 11'd255 : 11'd2047;
    sa     = op1[63];
    sb     = op2[63] ^ (op_type == 3'b001);
    ea     = (ea_f == 11'd0) ? 11'd1 : ea_f;
    eb     = (eb_f == 11'd0) ? 11'd1 : eb_f;
    nan_a  = (ea_f == emax_f) && (fa != 52'd0);
    nan_b  = (eb_f == emax_f) && (fb != 52'd0);
    snan_a = nan_a && !fa[51];
    snan_b = nan_b && !fb[51];
    inf_a  = (ea_f == emax_f) && (fa == 52'd0);
    inf_b  = (eb_f == emax_f) && (fb == 52'd0);
    // Single precision sits left-aligned in the 53-bit significand; rounding moves up by 29 bits.
    a_ge    = {ea, ea_f != 11'd0, fa} >= {eb, eb_f != 11'd0, fb};
    e_big   = a_ge ? ea : eb;
    d       = a_ge ? ea - eb : eb - ea;
    s_big   = a_ge ? sa : sb;
    eff_sub = sa ^ sb;
    x_big   = a_ge ? {ea_f != 11'd0, fa, 3'b0} : {eb_f != 11'd0, fb, 3'b0};
    x_small = a_ge ? {eb_f != 11'd0, fb, 3'b0} : {ea_f != 11'd0, fa, 3'b0};
    x_sh    = (x_small >> d) | {55'd0, |(x_small & ~({56{1'b1}} << d))};
    sum     = eff_sub ? {1'b0, x_big} - {1'b0, x_sh} : {1'b0, x_big} + {1'b0, x_sh};
    lz = 7'd56;
    for (int i = 0; i < 56; i++) if (sum[i]) lz = 7'(55 - i);
    if (sum[56]) begin
      sh = 7'd0;
      n  = {sum[56:2], sum[1] | sum[0]};
      er = $signed({3'b0, e_big}) + 14'sd1;
    end else begin
      // Without an underflow trap the shift stops at the minimum exponent, yielding a subnormal.
      sh = (!UnEn && ({4'b0, lz} >= e_big)) ? 7'(e_big - 11'd1) : lz;
      n  = sum[55:0] << sh;
      er = $signed({3'b0, e_big}) - $signed({7'b0, sh});
    end
    lsb     = P ? 6'd32 : 6'd3;
    keep    = 53'(n >> lsb);
    rbits   = n & ~({56{1'b1}} << lsb);
    half    = 56'd1 << (lsb - 6'd1);
    inexact = rbits != 56'd0;
    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = inexact & ~s_big;
      3'b011:  inc = inexact & s_big;
      default: inc = (rbits > half) || ((rbits == half) && keep[0]);
    endcase
    kr = {1'b0, keep} + {53'd0, inc};
    if (P ? kr[24] : kr[53]) begin
      kr = kr >> 1;
      er = er + 14'sd1;
    end
    hidden = P ? kr[23] : kr[52];
    tiny   = !hidden || (er < 14'sd1);
    ovf    = hidden && (er >= $signed({3'b0, emax_f}));
    adj    = P ? 14'sd192 : 14'sd1536;
    if (ovf && OvEn) er = er - adj;
    else if (tiny && UnEn) er = er + adj;
    fe = hidden ? er[10:0] : 11'd0;
    case (rm)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = !s_big;
      3'b011:  to_inf = s_big;
      default: to_inf = 1'b1;
    endcase
    result = P ? {s_big, fe[7:0], kr[22:0], 32'h0} : {s_big, fe, kr[51:0]};
    Flags  = {2'b00, ovf, tiny & (UnEn | inexact), inexact | (ovf & ~OvEn)};
    if (ovf && !OvEn) begin
      if (to_inf) result = P ? {s_big, 8'hff, 23'h0, 32'h0} : {s_big, 11'h7ff, 52'h0};
      else        result = P ? {s_big, 8'hfe, 23'h7fffff, 32'h0} : {s_big, 11'h7fe, {52{1'b1}}};
    end
    if (sum == 57'd0) begin
      result = {eff_sub ? (rm == 3'b011) : s_big, 63'd0};
      Flags  = '0;
    end
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      result = P ? {32'h7fc00000, 32'h0} : 64'h7ff8000000000000;
      Flags  = {snan_a | snan_b | (inf_a & inf_b & eff_sub), 4'b0000};
    end else if (inf_a || inf_b) begin
      result = P ? {inf_a ? sa : sb, 8'hff, 23'h0, 32'h0} : {inf_a ? sa : sb, 11'h7ff, 52'h0};
      Flags  = '0;
    end
    Denorm = P ? (result[62:55] == 8'd0) && (result[54:32] != 23'd0)
               : (result[62:52] == 11'd0) && (result[51:0] != 52'd0);
  end
endmodule

module fpadd_seq #(
  parameter int unsigned LAT = 2
) (
  input logic        clk,
  input logic        reset,
  fpadd_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] op_a, op_b;
  logic [2:0]  rm_q, op_q;
  logic        p_q, oven_q, unen_q;
  logic [63:0] fp_res;
  logic [4:0]  fp_flags;
  logic        fp_denorm;
  logic        retire;

  assign retire = bus.out_valid && bus.out_ready;

  fpadd u_fpadd (
    .result  (fp_res),
    .Flags   (fp_flags),
    .Denorm  (fp_denorm),
    .op1     (op_a),
    .op2     (op_b),
    .rm      (rm_q),
    .op_type (op_q),
    .P       (p_q),
    .OvEn    (oven_q),
    .UnEn    (unen_q)
  );

  // NOTE: state and outputs update with non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      op_a           <= 64'd0;
      op_b           <= 64'd0;
      rm_q           <= 3'd0;
      op_q           <= 3'd0;
      p_q            <= 1'b0;
      oven_q         <= 1'b0;
      unen_q         <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_res    <= 64'd0;
      bus.out_flags  <= 5'd0;
      bus.out_denorm <= 1'b0;
      bus.acc_flags  <= 5'd0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_a         <= bus.in_p ? {bus.in_a[31:0], 32'h0} : bus.in_a;
          op_b         <= bus.in_p ? {bus.in_b[31:0], 32'h0} : bus.in_b;
          rm_q         <= bus.in_rm;
          op_q         <= bus.in_op;
          p_q          <= bus.in_p;
          oven_q       <= bus.in_oven;
          unen_q       <= bus.in_unen;
          cnt          <= 4'(LAT - 1);
          bus.in_ready <= 1'b0;
          state        <= EXEC;
        end
        EXEC: if (cnt == 4'd0) begin
          bus.out_res    <= p_q ? {32'h0, fp_res[63:32]} : fp_res;
          bus.out_flags  <= fp_flags;
          bus.out_denorm <= fp_denorm;
          bus.out_valid  <= 1'b1;
          state          <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A clear coincident with a retire keeps only the retiring op's flags.
      if (bus.clr_flags)   bus.acc_flags <= retire ? bus.out_flags : 5'd0;
      else if (retire)     bus.acc_flags <= bus.acc_flags | bus.out_flags;
    end
  end
endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq: three instances (LAT=2, LAT=3, LAT=1) with
// hand-computed single/double results and an integer-exact model for the random run.
module tb_fpadd_seq;
  logic clk;
  logic rst1, rst2, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;

  fpadd_seq_if bus1 ();
  fpadd_seq_if bus2 ();
  fpadd_seq_if bus3 ();

  fpadd_seq #(.LAT(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  fpadd_seq #(.LAT(2)) u_dut2 (.clk(clk), .reset(rst2), .bus(bus2));
  fpadd_seq #(.LAT(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a, b;
    logic [2:0]  op, rm;
    logic        p;
    logic [63:0] res;
    logic [4:0]  flg;
    logic        dn;
  } vec_t;

  function automatic logic [31:0] int2sp(input int v);
    int m, k;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    k = 0;
    for (int i = 0; i < 31; i++) if (m >= (1 << i)) k = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + k);
    r[22:0]  = 23'((m << (23 - k)) & 32'h007fffff);
    return r;
  endfunction

  // Issue one op on the LAT=2 instance and count edges from accept until out_valid.
  task automatic issue2(input logic [63:0] a, b, input logic [2:0] op, rm, input logic p, output int lat);
    bus2.in_a = a; bus2.in_b = b; bus2.in_op = op; bus2.in_rm = rm; bus2.in_p = p;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 20) begin lat++; @(posedge clk); #1; end
  endtask

  task automatic retire2(input logic clr);
    bus2.out_ready = 1'b1; bus2.clr_flags = clr;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0; bus2.clr_flags = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus2.in_ready); end
    n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus2.out_valid); end
    n_checks++; if (bus2.out_res !== 64'd0) begin n_fail++; $display("FAIL reset_out_res: got %h want 0", bus2.out_res); end
    n_checks++; if (bus2.out_flags !== 5'd0) begin n_fail++; $display("FAIL reset_out_flags: got %b want 0", bus2.out_flags); end
    n_checks++; if (bus2.out_denorm !== 1'b0) begin n_fail++; $display("FAIL reset_out_denorm: got %b want 0", bus2.out_denorm); end
    n_checks++; if (bus2.acc_flags !== 5'd0) begin n_fail++; $display("FAIL reset_acc_flags: got %b want 0", bus2.acc_flags); end
    n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_lat1: got %b want 1", bus1.in_ready); end
    n_checks++; if (bus3.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_lat3: got %b want 1", bus3.in_ready); end
  endtask

  task automatic test_single_sub_ru;
    int lat;
    issue2(64'h3f800000, 64'h3f800000, 3'b001, 3'b010, 1'b1, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL subru_latency: got %0d want 2", lat); end
    n_checks++; if (bus2.out_res !== 64'h0) begin n_fail++; $display("FAIL subru_res: got %h want 0", bus2.out_res); end
    n_checks++; if (bus2.out_flags !== 5'd0) begin n_fail++; $display("FAIL subru_flags: got %b want 0", bus2.out_flags); end
    n_checks++; if (bus2.in_ready !== 1'b0) begin n_fail++; $display("FAIL subru_in_ready_done: got %b want 0", bus2.in_ready); end
    retire2(1'b0);
    n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL subru_retired_valid: got %b want 0", bus2.out_valid); end
    n_checks++; if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL subru_retired_ready: got %b want 1", bus2.in_ready); end
  endtask

  task automatic test_arith;
    vec_t vecs[5];
    int lat;
    vecs[0] = '{64'hdeadbeef_3f800000, 64'h3f800000, 3'b000, 3'b000, 1'b1, 64'h40000000, 5'd0, 1'b0};
    vecs[1] = '{64'h40400000, 64'h3f800000, 3'b001, 3'b000, 1'b1, 64'h40000000, 5'd0, 1'b0};
    vecs[2] = '{64'h3ff0000000000000, 64'h3ff0000000000000, 3'b000, 3'b000, 1'b0, 64'h4000000000000000, 5'd0, 1'b0};
    vecs[3] = '{64'h00800000, 64'h00400000, 3'b001, 3'b000, 1'b1, 64'h00400000, 5'd0, 1'b1};
    vecs[4] = '{64'h3f800000, 64'h40000000, 3'b001, 3'b000, 1'b1, 64'hbf800000, 5'd0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue2(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rm, vecs[i].p, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL arith%0d_latency: got %0d want 2", i, lat); end
      n_checks++; if (bus2.out_res !== vecs[i].res) begin n_fail++; $display("FAIL arith%0d_res: got %h want %h", i, bus2.out_res, vecs[i].res); end
      n_checks++; if (bus2.out_flags !== vecs[i].flg) begin n_fail++; $display("FAIL arith%0d_flags: got %b want %b", i, bus2.out_flags, vecs[i].flg); end
      n_checks++; if (bus2.out_denorm !== vecs[i].dn) begin n_fail++; $display("FAIL arith%0d_denorm: got %b want %b", i, bus2.out_denorm, vecs[i].dn); end
      retire2(1'b0);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    issue2(64'h3f800000, 64'h3f800000, 3'b000, 3'b000, 1'b1, lat);
    bus2.in_a = 64'h40800000; bus2.in_b = 64'h40800000;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      n_checks++; if (bus2.out_res !== 64'h40000000) begin n_fail++; $display("FAIL bp_res_c%0d: got %h want 40000000", i, bus2.out_res); end
      n_checks++; if (bus2.in_ready !== 1'b0 || bus2.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_c%0d: ready %b valid %b want 0 1", i, bus2.in_ready, bus2.out_valid); end
    end
    bus2.in_valid = 1'b0;
    retire2(1'b0);
    n_checks++; if (bus2.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_retire: got %b want 1", bus2.in_ready); end
    issue2(64'h40000000, 64'h3f800000, 3'b000, 3'b000, 1'b1, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
    n_checks++; if (bus2.out_res !== 64'h40400000) begin n_fail++; $display("FAIL bp_next_res: got %h want 40400000", bus2.out_res); end
    retire2(1'b0);
  endtask

  task automatic test_sticky;
    int lat;
    n_checks++; if (bus2.acc_flags !== 5'd0) begin n_fail++; $display("FAIL sticky_start: got %b want 0", bus2.acc_flags); end
    issue2(64'h3f800000, 64'h33800000, 3'b000, 3'b010, 1'b1, lat);
    n_checks++; if (bus2.out_res !== 64'h3f800001) begin n_fail++; $display("FAIL sticky_ru_res: got %h want 3f800001", bus2.out_res); end
    n_checks++; if (bus2.out_flags !== 5'b00001) begin n_fail++; $display("FAIL sticky_ru_flags: got %b want 00001", bus2.out_flags); end
    n_checks++; if (bus2.acc_flags !== 5'd0) begin n_fail++; $display("FAIL sticky_before_retire: got %b want 0", bus2.acc_flags); end
    retire2(1'b0);
    n_checks++; if (bus2.acc_flags !== 5'b00001) begin n_fail++; $display("FAIL sticky_accrue: got %b want 00001", bus2.acc_flags); end
    issue2(64'h3f800000, 64'h3f800000, 3'b000, 3'b010, 1'b1, lat);
    retire2(1'b0);
    n_checks++; if (bus2.acc_flags !== 5'b00001) begin n_fail++; $display("FAIL sticky_keep: got %b want 00001", bus2.acc_flags); end
    issue2(64'h3f800000, 64'h3f800000, 3'b000, 3'b010, 1'b1, lat);
    retire2(1'b1);
    n_checks++; if (bus2.acc_flags !== 5'd0) begin n_fail++; $display("FAIL sticky_clr_exact_retire: got %b want 0", bus2.acc_flags); end
    issue2(64'h3f800000, 64'h33800000, 3'b000, 3'b010, 1'b1, lat);
    retire2(1'b0);
    bus2.clr_flags = 1'b1; @(posedge clk); #1; bus2.clr_flags = 1'b0;
    n_checks++; if (bus2.acc_flags !== 5'd0) begin n_fail++; $display("FAIL sticky_clr_alone: got %b want 0", bus2.acc_flags); end
    issue2(64'h3f800000, 64'h33800000, 3'b000, 3'b010, 1'b1, lat);
    retire2(1'b1);
    n_checks++; if (bus2.acc_flags !== 5'b00001) begin n_fail++; $display("FAIL sticky_clr_inexact_retire: got %b want 00001", bus2.acc_flags); end
  endtask

  task automatic test_reset_exec;
    int lat, seen;
    bus3.in_a = 64'h3f800000; bus3.in_b = 64'h3f800000; bus3.in_op = 3'b000; bus3.in_rm = 3'b000; bus3.in_p = 1'b1;
    bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    lat = 0;
    while (!bus3.out_valid && lat < 20) begin lat++; @(posedge clk); #1; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lat3_latency: got %0d want 3", lat); end
    n_checks++; if (bus3.out_res !== 64'h40000000) begin n_fail++; $display("FAIL lat3_res: got %h want 40000000", bus3.out_res); end
    bus3.out_ready = 1'b1; @(posedge clk); #1; bus3.out_ready = 1'b0;
    bus3.in_b = 64'h33800000; bus3.in_rm = 3'b010;
    bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0; rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    n_checks++; if (bus3.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstexec_in_ready: got %b want 1", bus3.in_ready); end
    n_checks++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstexec_out_valid: got %b want 0", bus3.out_valid); end
    n_checks++; if (bus3.out_res !== 64'd0) begin n_fail++; $display("FAIL rstexec_out_res: got %h want 0", bus3.out_res); end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus3.out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstexec_no_result: got %0d valid cycles want 0", seen); end
    n_checks++; if (bus3.acc_flags !== 5'd0) begin n_fail++; $display("FAIL rstexec_acc_flags: got %b want 0", bus3.acc_flags); end
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int x, y, cyc, prev, n;
    logic [31:0] expv;
    cyc = 0; prev = 0;
    bus1.out_ready = 1'b1; bus1.in_op = 3'b001; bus1.in_rm = 3'b010; bus1.in_p = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x = int'($urandom_range(1, 1 << 20));
      y = (i % 10 == 0) ? x : int'($urandom_range(1, 1 << 20));
      expv = int2sp(x - y);
      bus1.in_a = {32'h0, int2sp(x)}; bus1.in_b = {32'h0, int2sp(y)};
      bus1.in_valid = 1'b1;
      n = 0;
      while (!bus1.in_ready && n < 10) begin @(posedge clk); #1; cyc++; n++; end
      @(posedge clk); #1; cyc++;
      if (i > 0) begin
        n_checks++; if (cyc - prev !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d want 3", i, cyc - prev); end
      end
      prev = cyc;
      n = 0;
      while (!bus1.out_valid && n < 10) begin @(posedge clk); #1; cyc++; n++; end
      n_checks++; if (bus1.out_res !== {32'h0, expv}) begin n_fail++; $display("FAIL b2b_res_%0d: %0d-%0d got %h want %h", i, x, y, bus1.out_res, {32'h0, expv}); end
      n_checks++; if (bus1.out_flags !== 5'd0) begin n_fail++; $display("FAIL b2b_flags_%0d: got %b want 0", i, bus1.out_flags); end
    end
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.in_rm = 0; bus1.in_op = 0; bus1.in_p = 0;
    bus1.in_oven = 0; bus1.in_unen = 0; bus1.out_ready = 0; bus1.clr_flags = 0;
    bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0; bus2.in_rm = 0; bus2.in_op = 0; bus2.in_p = 0;
    bus2.in_oven = 0; bus2.in_unen = 0; bus2.out_ready = 0; bus2.clr_flags = 0;
    bus3.in_valid = 0; bus3.in_a = 0; bus3.in_b = 0; bus3.in_rm = 0; bus3.in_op = 0; bus3.in_p = 0;
    bus3.in_oven = 0; bus3.in_unen = 0; bus3.out_ready = 0; bus3.clr_flags = 0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    test_reset();
    test_single_sub_ru();
    test_arith();
    test_backpressure();
    test_sticky();
    test_reset_exec();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpadd_seq.md
# fpadd_seq

Sequencing wrapper sitting directly upstream of the combinational `fpadd` datapath and consuming its outputs. Accepts one add/subtract request over a valid/ready handshake, registers operands and controls, holds them stable on `fpadd` for a fixed multicycle settle window, then captures result/flags/denorm and presents them over a second valid/ready handshake. Also keeps a sticky accrued-exception register, so the core sees a clean pipelined interface instead of a free-running combinational block.

## Interface
- `LAT`, default 2: cycles `fpadd` inputs are held before the result is sampled; legal range 1..15.
- `clk` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `in_a`, `in_b` in 64: operands; when `in_p`=1 only bits [31:0] are used (single precision).
- `in_rm` in 3: rounding mode, passed to `fpadd` (3'b010 = round up).
- `in_op` in 3: op type (3'b000 add, 3'b001 subtract), passed unchanged.
- `in_p` in 1: 1 = single, 0 = double.
- `in_oven`, `in_unen` in 1: overflow/underflow trap enables, passed unchanged.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes result.
- `out_res` out 64: result; single: {32'h0, fpadd result[63:32]}; double: fpadd result[63:0].
- `out_flags` out 5: `fpadd` Flags for this op.
- `out_denorm` out 1: `fpadd` Denorm for this op.
- `acc_flags` out 5: sticky OR of `out_flags` of every retired op.
- `clr_flags` in 1: clears `acc_flags`.
- Instantiates `fpadd` internally; ports to it: result, Flags, Denorm, op1, op2, rm, op_type, P, OvEn, UnEn.

## Operation
- Operand formatting at capture: `in_p`=1 -> op register = {in_a[31:0], 32'h0} (likewise b); `in_p`=0 -> full 64 bits.
- FSM states IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1, `out_valid`=0. On `in_valid`: register operands/controls, load counter = LAT-1, -> EXEC.
  - EXEC: `in_ready`=0. At each edge: counter==0 -> capture `fpadd` outputs into `out_res`/`out_flags`/`out_denorm`, -> DONE; else decrement.
  - DONE: `out_valid`=1, outputs held stable. On `out_ready`: -> IDLE; no new request accepted in this same cycle.
- `in_ready` is a pure function of state (IDLE), independent of `in_valid`.
- `acc_flags`: on retire (`out_valid`&`out_ready`) <= acc | out_flags. `clr_flags` alone -> 0. `clr_flags` coincident with retire -> `acc_flags` = out_flags of the retiring op (clear first, then accrue).
- Operand/control registers change only on accept; `fpadd` inputs constant throughout EXEC/DONE.
- `in_op`/`in_rm` values outside the listed encodings are forwarded unchecked; behaviour is `fpadd`'s.

## Timing
- Reset values: state IDLE, `in_ready`=1 after reset deasserts, `out_valid`=0, `out_res`=0, `out_flags`=0, `out_denorm`=0, `acc_flags`=0, counter 0, operand regs 0.
- Reset mid-operation (EXEC or DONE): in-flight op dropped, no flag accrual, IDLE next cycle.
- Accept at edge t -> capture at edge t+LAT -> `out_valid` high in cycle after t+LAT. Latency = LAT cycles.
- Retire at edge r -> `in_ready` high from r; next accept no earlier than edge r+1. Max throughput: one op per LAT+2 cycles with `out_ready` held high.
- `out_ready` low: DONE holds indefinitely, outputs bit-stable.
- `in_valid` high while not ready: ignored, no state change.

## Test plan
- Single sub RU, LAT=2: in_a=3f800000, in_b=3f800000, op=001, rm=010, p=1 -> out_valid 2 cycles after accept, out_res=0000000000000000, out_flags=0.
- Single add: 3f800000 + 3f800000, op=000 -> out_res=0000000040000000; single sub 40400000 - 3f800000 -> 0000000040000000.
- Backpressure: out_ready low 5 cycles after out_valid -> out_res/out_flags unchanged, in_ready=0, in_valid pulses ignored; retire, then accept on next cycle.
- Sticky flags: op producing inexact (3f800000 + 33800000, rm=010 -> 3f800001), then exact op -> acc_flags keeps inexact bit; clr_flags with simultaneous retire of exact op -> acc_flags=0.
- Reset in EXEC (assert at cycle 1 of LAT=3 op) -> next cycle IDLE, out_valid=0, acc_flags=0, no result emitted.
- Back-to-back 100 random single-precision sub RU ops with out_ready=1, LAT=1 -> each result matches golden vectors, accept spacing exactly 3 cycles.
